// File: rtl/dp_seq_pkg.sv
// Shared types and widths for the dot-product sequencer that feeds the int8 MAC.
package dp_seq_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        HOLD   = 3'd2,
        WAIT   = 3'd3,
        SETTLE = 3'd4,
        RESULT = 3'd5
    } state_t;

    typedef struct packed {
        logic                   last;
        logic signed [OP_W-1:0] a;
        logic signed [OP_W-1:0] b;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head read and no push/pop bypass.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Feeds buffered int8 pairs to the MAC one at a time and reports each vector's
// dot product as the change in the never-cleared MAC accumulator.
module dot_product_sequencer
    import dp_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             mac_valid,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    input  logic [ACC_W-1:0] mac_y,
    input  logic             mac_overflow,
    input  logic             mac_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    fifo_entry_t      din;
    fifo_entry_t      head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ACC_W-1:0] base;
    logic [CNT_W-1:0] count;
    logic             sticky_ovf;
    logic             first_flag;
    logic             cur_last;

    assign din      = '{last: in_last, a: in_a, b: in_b};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == HOLD);
    assign busy     = (state != IDLE);

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // The head stays in the FIFO through ISSUE and HOLD because the MAC
    // samples its operands during the HOLD cycle; it is popped leaving HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mac_valid  <= 1'b0;
            mac_a      <= '0;
            mac_b      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
            base       <= '0;
            count      <= '0;
            sticky_ovf <= 1'b0;
            first_flag <= 1'b1;
            cur_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (first_flag)
                            base <= mac_y;
                        mac_valid <= 1'b1;
                        mac_a     <= head.a;
                        mac_b     <= head.b;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mac_valid <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    cur_last <= head.last;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mac_done) begin
                        sticky_ovf <= sticky_ovf | mac_overflow;
                        if (count != CNT_MAX)
                            count <= count + 1'b1;
                        state <= SETTLE;
                    end
                end
                // The accumulator has absorbed the last product by now.
                SETTLE: begin
                    if (cur_last) begin
                        out_data   <= mac_y - base;
                        out_count  <= count;
                        out_ovf    <= sticky_ovf;
                        out_valid  <= 1'b1;
                        count      <= '0;
                        sticky_ovf <= 1'b0;
                        first_flag <= 1'b1;
                        state      <= RESULT;
                    end else begin
                        first_flag <= 1'b0;
                        if (!empty) begin
                            mac_valid <= 1'b1;
                            mac_a     <= head.a;
                            mac_b     <= head.b;
                            state     <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer driving a behavioural int8 MAC model
// with IDLE->LOAD->PROCESSING->DONE timing and a never-cleared accumulator.
module tb_dot_product_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inA;
    logic [7:0]  inB;
    logic        inLast;
    logic        macValid;
    logic [7:0]  macA;
    logic [7:0]  macB;
    logic [31:0] macY;
    logic        macOverflow;
    logic        macDone;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [CNT_W-1:0] outCount;
    logic        outOvf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_product_sequencer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .in_a         (inA),
        .in_b         (inB),
        .in_last      (inLast),
        .mac_valid    (macValid),
        .mac_a        (macA),
        .mac_b        (macB),
        .mac_y        (macY),
        .mac_overflow (macOverflow),
        .mac_done     (macDone),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_data     (outData),
        .out_count    (outCount),
        .out_ovf      (outOvf),
        .busy         (busy)
    );

    // Behavioural MAC: accumulator updates on the edge that ends DONE.
    logic [1:0]         macState;
    logic signed [7:0]  macRa;
    logic signed [7:0]  macRb;
    logic signed [31:0] macAcc;
    logic signed [31:0] macProd;
    logic signed [31:0] macSum;
    logic               preloadEn;
    logic [31:0]        preloadVal;

    assign macSum      = macAcc + macProd;
    assign macY        = macAcc;
    assign macDone     = (macState == 2'd3);
    assign macOverflow = macDone && (macAcc[31] == macProd[31]) && (macSum[31] != macAcc[31]);

    always @(posedge clk) begin
        if (reset) begin
            macState <= 2'd0;
            macAcc   <= '0;
            macRa    <= '0;
            macRb    <= '0;
            macProd  <= '0;
        end else if (preloadEn) begin
            macAcc <= preloadVal;
        end else begin
            case (macState)
                2'd0: if (macValid) macState <= 2'd1;
                2'd1: begin
                    macRa    <= macA;
                    macRb    <= macB;
                    macState <= 2'd2;
                end
                2'd2: begin
                    macProd  <= macRa * macRb;
                    macState <= 2'd3;
                end
                default: begin
                    macAcc   <= macSum;
                    macState <= 2'd0;
                end
            endcase
        end
    end

    // Cycle counter plus pulse bookkeeping for spacing / full observations.
    int   cycle = 0;
    int   pulseCount = 0;
    int   lastPulse = -1;
    int   badSpacing = 0;
    logic seenFull = 1'b0;
    logic spacingEn = 1'b0;

    always @(posedge clk) begin
        cycle = cycle + 1;
        if (macValid)
            pulseCount = pulseCount + 1;
        if (!spacingEn) begin
            lastPulse  = -1;
            badSpacing = 0;
            seenFull   = 1'b0;
        end else begin
            if (!inReady)
                seenFull = 1'b1;
            if (macValid) begin
                if (lastPulse >= 0 && (cycle - lastPulse) != 5)
                    badSpacing = badSpacing + 1;
                lastPulse = cycle;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        inValid = 1'b1;
        inA     = a;
        inB     = b;
        inLast  = last;
        n = 0;
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("push_accept", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic collectResult(input string tag, input logic [31:0] expData,
                                 input logic [31:0] expCount, input logic expOvf);
        int n;
        n = 0;
        while (!outValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        checkOutput({tag, "_data"}, outData, expData);
        checkOutput({tag, "_count"}, {{(32-CNT_W){1'b0}}, outCount}, expCount);
        checkOutput({tag, "_ovf"}, {31'd0, outOvf}, {31'd0, expOvf});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, "_valid_clr"}, {31'd0, outValid}, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, inReady}, 32'd1);
        checkOutput({tag, "_mac_valid"}, {31'd0, macValid}, 32'd0);
        checkOutput({tag, "_mac_ab"}, {16'd0, macA, macB}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'd0, outValid}, 32'd0);
        checkOutput({tag, "_out_data"}, outData, 32'd0);
        checkOutput({tag, "_out_count"}, {{(32-CNT_W){1'b0}}, outCount}, 32'd0);
        checkOutput({tag, "_out_ovf"}, {31'd0, outOvf}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int p0;
        int tIssue;
        int tResult;

        reset      = 1'b1;
        inValid    = 1'b0;
        inA        = '0;
        inB        = '0;
        inLast     = 1'b0;
        outReady   = 1'b0;
        preloadEn  = 1'b0;
        preloadVal = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResetState("rst0");

        // Single-pair vector and issue-to-result latency.
        applyStimulus(8'd3, 8'd4, 1'b1);
        n = 0;
        while (!macValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1_issue_seen", {31'd0, macValid}, 32'd1);
        tIssue = cycle;
        n = 0;
        while (!outValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        tResult = cycle;
        checkOutput("t1_latency", tResult - tIssue, 32'd5);
        collectResult("t1", 32'd12, 32'd1, 1'b0);

        // Accumulator is non-zero before the vector; base must be subtracted.
        applyStimulus(8'd10, 8'd10, 1'b1);
        collectResult("t2pre", 32'd100, 32'd1, 1'b0);
        applyStimulus(8'd2, 8'd5, 1'b0);
        applyStimulus(-8'sd3, 8'd7, 1'b0);
        applyStimulus(8'd127, 8'd127, 1'b1);
        collectResult("t2", 32'd16118, 32'd3, 1'b0);

        // DEPTH+2 back-to-back pairs (i,i): sum of squares 1..10 = 385.
        p0 = pulseCount;
        spacingEn = 1'b1;
        for (int i = 1; i <= DEPTH + 2; i++)
            applyStimulus(i[7:0], i[7:0], (i == DEPTH + 2));
        n = 0;
        while (!outValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3_seen_full", {31'd0, seenFull}, 32'd1);
        checkOutput("t3_bad_spacing", badSpacing, 32'd0);
        checkOutput("t3_pulses", pulseCount - p0, DEPTH + 2);
        spacingEn = 1'b0;
        collectResult("t3", 32'd385, DEPTH + 2, 1'b0);

        // Back-pressure on the result port while new data arrives.
        applyStimulus(8'd2, 8'd3, 1'b1);
        n = 0;
        while (!outValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        p0 = pulseCount;
        applyStimulus(8'd4, 8'd4, 1'b1);
        for (int i = 0; i < 9; i++) begin
            checkOutput("t4_hold_data", outData, 32'd6);
            @(negedge clk);
        end
        checkOutput("t4_hold_valid", {31'd0, outValid}, 32'd1);
        checkOutput("t4_hold_count", {{(32-CNT_W){1'b0}}, outCount}, 32'd1);
        checkOutput("t4_no_issue", pulseCount - p0, 32'd0);
        collectResult("t4a", 32'd6, 32'd1, 1'b0);
        collectResult("t4b", 32'd16, 32'd1, 1'b0);

        // Reset while the second pair of a four-pair vector is in WAIT.
        p0 = pulseCount;
        applyStimulus(8'd1, 8'd2, 1'b0);
        applyStimulus(8'd3, 8'd4, 1'b0);
        applyStimulus(8'd5, 8'd6, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b1);
        n = 0;
        while (pulseCount < p0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_second_issue", pulseCount - p0, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkResetState("t5rst");
        repeat (6) @(negedge clk);
        checkOutput("t5_fifo_empty_idle", {31'd0, busy}, 32'd0);
        applyStimulus(8'd1, 8'd1, 1'b1);
        collectResult("t5", 32'd1, 32'd1, 1'b0);

        // Drive the accumulator across +2^31 with (-128)*(-128) products.
        preloadEn  = 1'b1;
        preloadVal = 32'h7FFF_0000;
        @(negedge clk);
        preloadEn = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(8'h80, 8'h80, (i == 3));
        collectResult("t6ovf", 32'h0001_0000, 32'd4, 1'b1);
        applyStimulus(8'd1, 8'd1, 1'b1);
        collectResult("t6next", 32'd1, 32'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
